// File: rtl/fir_filter.sv
// 16-tap fixed-coefficient direct-form FIR low-pass filter.
// Bit-exact full-precision output registered one cycle after the delay line.
module fir_filter #(
  parameter int unsigned TAPS = 16,
  parameter int unsigned DW   = 16,
  parameter int unsigned OW   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] data_i,
  output logic signed [OW-1:0] data_o
);

  localparam int unsigned HALF = TAPS / 2;
  localparam int unsigned PW   = DW + 1;

  localparam logic signed [15:0] COEF [TAPS] = '{
    -16'sd12,  -16'sd30,   16'sd0,    16'sd120,
     16'sd330,  16'sd600,  16'sd850,  16'sd1000,
     16'sd1000, 16'sd850,  16'sd600,  16'sd330,
     16'sd120,  16'sd0,   -16'sd30,  -16'sd12
  };

  logic signed [DW-1:0] x [TAPS];
  logic signed [OW-1:0] acc;
  logic signed [PW-1:0] pre;
  logic signed [OW-1:0] prod;

  // Symmetric pre-add halves the multiplier count; widths keep it exact.
  always_comb begin
    acc  = '0;
    pre  = '0;
    prod = '0;
    for (int i = 0; i < int'(HALF); i++) begin
      pre  = PW'(x[i]) + PW'(x[TAPS-1-i]);
      prod = OW'(pre) * OW'(COEF[i]);
      acc  = acc + prod;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(TAPS); k++) begin
        x[k] <= '0;
      end
      data_o <= '0;
    end else begin
      if (valid_i) begin
        x[0] <= data_i;
        for (int k = 1; k < int'(TAPS); k++) begin
          x[k] <= x[k-1];
        end
      end
      data_o <= acc;
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: randomized streams against a
// history-queue convolution model computed in 64-bit arithmetic.
module tb_fir_filter;

  logic               clk_i;
  logic               rst_i;
  logic               valid_i;
  logic signed [15:0] data_i;
  logic signed [31:0] data_o;

  int checks;
  int errors;

  int h [16] = '{-12, -30, 0, 120, 330, 600, 850, 1000,
                 1000, 850, 600, 330, 120, 0, -30, -12};

  // Accepted samples since the last reset, newest first.
  int hist [$];
  longint exp_y;

  fir_filter #(.TAPS(16), .DW(16), .OW(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .data_o  (data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic longint conv();
    longint s = 0;
    for (int k = 0; k < 16 && k < hist.size(); k++) begin
      s += longint'(h[k]) * longint'(hist[k]);
    end
    return s;
  endfunction

  // Drive one cycle and advance the model; outputs are sampled 1 time unit later.
  task automatic tick(input logic rst, input logic vld, input int d);
    longint y_next;
    rst_i   = rst;
    valid_i = vld;
    data_i  = 16'(d);
    y_next  = conv();
    @(posedge clk_i);
    if (rst) begin
      hist.delete();
      exp_y = 0;
    end else begin
      exp_y = y_next;
      if (vld) begin
        hist.push_front(d);
        if (hist.size() > 16) void'(hist.pop_back());
      end
    end
    #1;
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, rand_sample());
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, rand_sample());
      checks++;
      if (data_o !== 32'sd0) begin
        errors++;
        $display("FAIL reset_during cyc=%0d got %0d want 0", i, data_o);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, rand_sample());
      checks++;
      if (data_o !== 32'sd0) begin
        errors++;
        $display("FAIL reset_after cyc=%0d got %0d want 0", i, data_o);
      end
    end
    tick(1'b0, 1'b1, 1234);
    checks++;
    if (data_o !== 32'sd0) begin
      errors++;
      $display("FAIL reset_first_sample got %0d want 0", data_o);
    end
    tick(1'b0, 1'b0, 0);
    checks++;
    if (data_o !== 32'(-12 * 1234)) begin
      errors++;
      $display("FAIL reset_first_product got %0d want %0d", data_o, -12 * 1234);
    end
  endtask

  task automatic test_impulse();
    tick(1'b1, 1'b0, 0);
    tick(1'b0, 1'b1, 1);
    for (int i = 0; i < 24; i++) begin
      int want;
      tick(1'b0, 1'b1, 0);
      want = (i < 16) ? h[i] : 0;
      checks++;
      if (data_o !== 32'(want)) begin
        errors++;
        $display("FAIL impulse tap=%0d got %0d want %0d", i, data_o, want);
      end
    end
  endtask

  task automatic test_step_gating();
    logic signed [31:0] prev;
    int accepted = 0;
    tick(1'b1, 1'b0, 0);
    while (accepted < 16) begin
      logic vld;
      vld = (accepted % 2 == 0) ? 1'b1 : 1'b0;
      vld = vld | ($urandom_range(3) == 0);
      prev = data_o;
      tick(1'b0, vld, vld ? 1000 : rand_sample());
      if (vld) accepted++;
      checks++;
      if (data_o !== 32'(exp_y)) begin
        errors++;
        $display("FAIL step_model got %0d want %0d", data_o, exp_y);
      end
      prev = data_o;
      tick(1'b0, 1'b0, rand_sample());
      tick(1'b0, 1'b0, rand_sample());
      checks++;
      if (data_o !== prev && accepted > 0 && data_o !== 32'(exp_y)) begin
        errors++;
        $display("FAIL step_hold got %0d want %0d", data_o, exp_y);
      end
    end
    checks++;
    if (data_o !== 32'sd5716000) begin
      errors++;
      $display("FAIL step_settle got %0d want 5716000", data_o);
    end
  endtask

  task automatic test_extremes();
    int pat;
    tick(1'b1, 1'b0, 0);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, -32768);
    tick(1'b0, 1'b0, 0);
    checks++;
    if (data_o !== -32'sd187301888) begin
      errors++;
      $display("FAIL extreme_neg got %0d want -187301888", data_o);
    end
    // Positive taps see -32768, negative taps see +32767: all products negative.
    for (int i = 0; i < 16; i++) begin
      pat = (h[15 - i] < 0) ? 32767 : -32768;
      tick(1'b0, 1'b1, pat);
    end
    tick(1'b0, 1'b0, 0);
    checks++;
    if (data_o !== -32'sd192806828) begin
      errors++;
      $display("FAIL extreme_alt got %0d want -192806828", data_o);
    end
    checks++;
    if (data_o !== 32'(exp_y)) begin
      errors++;
      $display("FAIL extreme_model got %0d want %0d", data_o, exp_y);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 1'b0, 0);
    for (int i = 0; i < 200; i++) begin
      tick(1'b0, 1'b1, rand_sample());
      checks++;
      if (data_o !== 32'(exp_y)) begin
        errors++;
        $display("FAIL b2b cyc=%0d got %0d want %0d", i, data_o, exp_y);
      end
    end
  endtask

  task automatic test_midstream_reset();
    real ph;
    int  s;
    logic vld;
    for (int i = 0; i < 2000; i++) begin
      ph = 2.0 * 3.14159265358979 * real'(i) / 37.0;
      s  = int'(30000.0 * $sin(ph)) + int'($urandom_range(5000)) - 2500;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      vld = ($urandom_range(4) != 0);
      if (i == 1000) begin
        tick(1'b1, 1'b1, s);
        checks++;
        if (data_o !== 32'sd0) begin
          errors++;
          $display("FAIL mid_reset got %0d want 0", data_o);
        end
      end else begin
        tick(1'b0, vld, s);
        checks++;
        if (data_o !== 32'(exp_y)) begin
          errors++;
          $display("FAIL sine cyc=%0d got %0d want %0d", i, data_o, exp_y);
        end
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_y   = 0;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    tick(1'b1, 1'b0, 0);
    checks++;
    if (data_o !== 32'sd0) begin
      errors++;
      $display("FAIL initial_reset got %0d want 0", data_o);
    end
    test_reset();
    test_impulse();
    test_step_gating();
    test_extremes();
    test_back_to_back();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
